// File: rtl/top_memoryaccess_if.sv
// ---------------------------------------------------------------------------
// top_memoryaccess_if
// Data-bus bundle between the memory-access stage and the data memory.
//   master : memory-access stage (drives request, write enable, address,
//            lane-steered write data and byte strobes; receives ack/rdata)
//   slave  : data memory / bus fabric
// Signals:
//   dbus_req    request, held until acknowledged
//   dbus_we     1 = store, 0 = load
//   dbus_addr   byte address
//   dbus_wdata  lane-steered store data
//   dbus_wstrb  byte strobes (all zero for loads)
//   dbus_ack    transfer done; dbus_rdata valid in the same cycle
//   dbus_rdata  read data
// ---------------------------------------------------------------------------
interface top_memoryaccess_if #(
    parameter int XLEN = 32
);
    logic              dbus_req;
    logic              dbus_we;
    logic [XLEN-1:0]   dbus_addr;
    logic [XLEN-1:0]   dbus_wdata;
    logic [XLEN/8-1:0] dbus_wstrb;
    logic              dbus_ack;
    logic [XLEN-1:0]   dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        input  dbus_ack, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_wstrb,
        output dbus_ack, dbus_rdata
    );
endinterface

// File: rtl/top_memoryaccess.sv
// ---------------------------------------------------------------------------
// top_memoryaccess
// Memory-access pipeline stage. Takes the execute->memory latch (*_em),
// performs loads/stores over the data bus (req/ack), steers store bytes onto
// their lanes, extends load data, and latches results for writeback (*_mw).
// The core state machine is stalled while a bus transfer is outstanding.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   phase_memoryaccess    memory phase from the state machine
//   *_em                  execute->memory latch contents
//   dbus                  data-bus interface (master modport)
//   *_mw                  memory->writeback latch contents
//   mem_rdata_mw          extended load data (0 for non-loads)
//   mem_fault_mw          misaligned or timed-out access
//   stall_memoryaccess    stall request (combinational)
//
// Decoded-op field positions are parameters so they can be matched to the
// core's op encoding. Only XLEN = 32 is supported.
//
// Optional feature macro: MEMACC_TIMEOUT_EN
//   defined   : 8-bit bus watchdog; after TIMEOUT_CYCLES BUSY cycles without
//               ack the transfer is abandoned and reported as a fault.
//   undefined : BUSY waits for ack indefinitely.
// ---------------------------------------------------------------------------
module top_memoryaccess #(
    parameter int XLEN             = 32,
    parameter int OPLEN            = 8,
    parameter int MEM_LOAD_BIT     = 0,
    parameter int MEM_STORE_BIT    = 1,
    parameter int MEM_SIZE_LSB     = 2,
    parameter int MEM_UNSIGNED_BIT = 4,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               phase_memoryaccess,
    input  logic [OPLEN-1:0]   decoded_op_em,
    input  logic [XLEN-1:0]    rs2data_em,
    input  logic               jump_state_em,
    input  logic [4:0]         rdsel_em,
    input  logic [XLEN-1:0]    next_pc_em,
    input  logic [XLEN-1:0]    alu_out_em,
    top_memoryaccess_if.master dbus,
    output logic [OPLEN-1:0]   decoded_op_mw,
    output logic               jump_state_mw,
    output logic [4:0]         rdsel_mw,
    output logic [XLEN-1:0]    next_pc_mw,
    output logic [XLEN-1:0]    alu_out_mw,
    output logic [XLEN-1:0]    mem_rdata_mw,
    output logic               mem_fault_mw,
    output logic               stall_memoryaccess
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("top_memoryaccess supports XLEN = 32 only");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit watchdog counter");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {wstrb, wdata}: store data replicated across lanes, strobes
    // shifted to the addressed byte.
    function automatic logic [35:0] store_steer(input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic [31:0] data);
        logic [35:0] res;
        case (size)
            2'b00:   res = {4'b0001 << lane, {4{data[7:0]}}};
            2'b01:   res = {4'b0011 << lane, {2{data[15:0]}}};
            default: res = {4'b1111, data};
        endcase
        return res;
    endfunction

    // Shift the addressed bytes down, truncate to size, sign/zero extend.
    function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                                input logic        uns,
                                                input logic [1:0]  lane,
                                                input logic [31:0] data);
        logic [31:0] sh;
        logic [31:0] res;
        sh = data >> {lane, 3'b000};
        case (size)
            2'b00:   res = {{24{~uns & sh[7]}}, sh[7:0]};
            2'b01:   res = {{16{~uns & sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        is_load_s, is_store_s, mem_op_s, misaligned_s;
    logic [1:0]  size_s;
    logic        start_s, finish_s, timeout_s;
    logic        mw_load_s, mw_fault_s;
    logic [31:0] mw_rdata_s;
    logic [35:0] steer_s;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [31:0] rdata_cap_r;
    logic        fault_cap_r;

    assign is_load_s    = decoded_op_em[MEM_LOAD_BIT];
    assign is_store_s   = decoded_op_em[MEM_STORE_BIT];
    assign mem_op_s     = is_load_s | is_store_s;
    assign size_s       = decoded_op_em[MEM_SIZE_LSB +: 2];
    // Size 11 is treated as a word, so bit 1 alone selects word alignment.
    assign misaligned_s = (size_s[1] & (|alu_out_em[1:0])) |
                          ((size_s == 2'b01) & alu_out_em[0]);
    assign steer_s      = store_steer(size_s, alu_out_em[1:0], rs2data_em);
    assign finish_s     = (state_r == ST_BUSY) & (dbus.dbus_ack | timeout_s);

`ifdef MEMACC_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt_r;

    // Ack in the limit cycle wins: timeout only fires when ack is absent.
    assign timeout_s = (state_r == ST_BUSY) & ~dbus.dbus_ack &
                       ((tmo_cnt_r + 8'd1) == TMO_LIMIT);

    // Watchdog: cleared on entering BUSY, counts BUSY cycles without ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= 8'd0;
        end else if (start_s) begin
            tmo_cnt_r <= 8'd0;
        end else if ((state_r == ST_BUSY) && !dbus.dbus_ack) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, stall, bus start and writeback-latch enable/data.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        stall_memoryaccess = 1'b0;
        mw_load_s   = 1'b0;
        mw_rdata_s  = 32'd0;
        mw_fault_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (phase_memoryaccess && mem_op_s && !misaligned_s) begin
                    start_s            = 1'b1;
                    stall_memoryaccess = 1'b1;
                    state_nxt_s        = ST_BUSY;
                end else if (phase_memoryaccess) begin
                    // Non-memory op or misaligned access: no bus, latch now.
                    mw_load_s  = 1'b1;
                    mw_fault_s = mem_op_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                stall_memoryaccess = 1'b1;
                if (finish_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_DONE: begin
                mw_load_s   = 1'b1;
                mw_rdata_s  = rdata_cap_r;
                mw_fault_s  = fault_cap_r;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bus outputs: loaded on start, held through BUSY, req dropped on finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus.dbus_req   <= 1'b0;
            dbus.dbus_we    <= 1'b0;
            dbus.dbus_addr  <= '0;
            dbus.dbus_wdata <= '0;
            dbus.dbus_wstrb <= '0;
            size_r          <= 2'b00;
            uns_r           <= 1'b0;
        end else if (start_s) begin
            dbus.dbus_req   <= 1'b1;
            dbus.dbus_we    <= is_store_s;
            dbus.dbus_addr  <= alu_out_em;
            dbus.dbus_wdata <= is_store_s ? steer_s[31:0] : 32'd0;
            dbus.dbus_wstrb <= is_store_s ? steer_s[35:32] : 4'b0000;
            size_r          <= size_s;
            uns_r           <= decoded_op_em[MEM_UNSIGNED_BIT];
        end else if (finish_s) begin
            dbus.dbus_req   <= 1'b0;
        end else begin
            dbus.dbus_req   <= dbus.dbus_req;
        end
    end

    // Capture extended read data (or the timeout fault) at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_cap_r <= 32'd0;
            fault_cap_r <= 1'b0;
        end else if (finish_s) begin
            rdata_cap_r <= (dbus.dbus_ack && !dbus.dbus_we) ?
                           load_extend(size_r, uns_r, dbus.dbus_addr[1:0], dbus.dbus_rdata) :
                           32'd0;
            fault_cap_r <= timeout_s;
        end else begin
            rdata_cap_r <= rdata_cap_r;
            fault_cap_r <= fault_cap_r;
        end
    end

    // Memory->writeback latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decoded_op_mw <= '0;
            jump_state_mw <= 1'b0;
            rdsel_mw      <= 5'd0;
            next_pc_mw    <= '0;
            alu_out_mw    <= '0;
            mem_rdata_mw  <= '0;
            mem_fault_mw  <= 1'b0;
        end else if (mw_load_s) begin
            decoded_op_mw <= decoded_op_em;
            jump_state_mw <= jump_state_em;
            rdsel_mw      <= rdsel_em;
            next_pc_mw    <= next_pc_em;
            alu_out_mw    <= alu_out_em;
            mem_rdata_mw  <= mw_rdata_s;
            mem_fault_mw  <= mw_fault_s;
        end else begin
            mem_fault_mw  <= mem_fault_mw;
        end
    end

endmodule
